// File: rtl/my_mod_gen_v1.sv
// Square-wave bias-modulation generator: alternates between high and low DAC levels,
// N clocks each, with a phase flag and a one-cycle strobe on every phase change.
// Settings are shadowed at each period start, so a period never mixes old and new values.
//
// Parameters:
//   DAC_BIT        width of the signed DAC word (default 14)
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           run enable; when dropped, the current period still completes
//   i_freq_cnt     half-period length N in clocks; 0 and 1 are treated as 2
//   i_amp_h        signed level for the high half
//   i_amp_l        signed level for the low half
//   i_mod_offset   signed offset added to both levels
//   o_status       1 = high half, 0 = low half or idle
//   o_trig         one-cycle pulse on the first cycle of each half
//   o_mod_dac      saturated signed DAC word; 0 when idle
//   o_period_cnt   count of completed full periods; wraps
//   o_cstate       FSM state          (only with MOD_GEN_DBG_EN)
//   o_half_cnt     half-period count  (only with MOD_GEN_DBG_EN)
//
// Build option: define MOD_GEN_DBG_EN to add the o_cstate and o_half_cnt debug ports.
module my_mod_gen_v1 #(
  parameter int DAC_BIT = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [31:0]               i_freq_cnt,
  input  logic signed [31:0]        i_amp_h,
  input  logic signed [31:0]        i_amp_l,
  input  logic signed [31:0]        i_mod_offset,
  output logic                      o_status,
  output logic                      o_trig,
  output logic signed [DAC_BIT-1:0] o_mod_dac,
  output logic [31:0]               o_period_cnt
`ifdef MOD_GEN_DBG_EN
  ,
  output logic [1:0]                o_cstate,
  output logic [31:0]               o_half_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic signed [32:0] DAC_MAX =
    (33'sd1 <<< (DAC_BIT - 1)) - 33'sd1;
  localparam logic signed [32:0] DAC_MIN =
    -(33'sd1 <<< (DAC_BIT - 1));

  state_t             state, state_n;
  logic [31:0]        half_cnt, half_cnt_n;
  logic [31:0]        n_q, n_n;
  logic signed [31:0] ah_q, ah_n;
  logic signed [31:0] al_q, al_n;
  logic signed [31:0] of_q, of_n;
  logic [31:0]        per_n;
  logic               load;
  logic               last;
  logic               status_n;
  logic               trig_n;
  logic signed [DAC_BIT-1:0] dac_n;

  // Sum is taken in 33 bits so that extreme 32-bit operands cannot overflow.
  function automatic logic signed [DAC_BIT-1:0] sat(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s > DAC_MAX) s = DAC_MAX;
    else if (s < DAC_MIN) s = DAC_MIN;
    return s[DAC_BIT-1:0];
  endfunction

  assign last = (half_cnt == n_q - 32'd1);

  always_comb begin
    state_n    = state;
    half_cnt_n = half_cnt + 32'd1;
    per_n      = o_period_cnt;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        half_cnt_n = '0;
        if (i_en) begin
          state_n = HIGH;
          load    = 1'b1;
        end
      end
      HIGH: begin
        if (last) begin
          state_n    = LOW;
          half_cnt_n = '0;
        end
      end
      LOW: begin
        if (last) begin
          half_cnt_n = '0;
          per_n      = o_period_cnt + 32'd1;
          if (i_en) begin
            state_n = HIGH;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        half_cnt_n = '0;
      end
    endcase

    n_n  = n_q;
    ah_n = ah_q;
    al_n = al_q;
    of_n = of_q;
    if (load) begin
      n_n  = (i_freq_cnt < 32'd2) ? 32'd2 : i_freq_cnt;
      ah_n = i_amp_h;
      al_n = i_amp_l;
      of_n = i_mod_offset;
    end

    // Outputs are precomputed from the next state so they land on the
    // same edge as the state change.
    status_n = (state_n == HIGH);
    trig_n   = (state_n != state) && (state_n != IDLE);
    dac_n    = '0;
    if (state_n == HIGH) dac_n = sat(ah_n, of_n);
    else if (state_n == LOW) dac_n = sat(al_n, of_n);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      half_cnt     <= '0;
      n_q          <= 32'd2;
      ah_q         <= '0;
      al_q         <= '0;
      of_q         <= '0;
      o_status     <= 1'b0;
      o_trig       <= 1'b0;
      o_mod_dac    <= '0;
      o_period_cnt <= '0;
    end else begin
      state        <= state_n;
      half_cnt     <= half_cnt_n;
      n_q          <= n_n;
      ah_q         <= ah_n;
      al_q         <= al_n;
      of_q         <= of_n;
      o_status     <= status_n;
      o_trig       <= trig_n;
      o_mod_dac    <= dac_n;
      o_period_cnt <= per_n;
    end
  end

`ifdef MOD_GEN_DBG_EN
  assign o_cstate   = state;
  assign o_half_cnt = half_cnt;
`endif

endmodule

// File: tb/tb_my_mod_gen_v1.sv
// Directed bench for my_mod_gen_v1: a table of waveform cases
// plus hand sequences for reset, shadowing and stop behaviour.
module tb_my_mod_gen_v1;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_en = 1'b0;
  logic [31:0]        i_freq_cnt = 32'd10;
  logic signed [31:0] i_amp_h = '0;
  logic signed [31:0] i_amp_l = '0;
  logic signed [31:0] i_mod_offset = '0;
  logic               o_status;
  logic               o_trig;
  logic signed [13:0] o_mod_dac;
  logic [31:0]        o_period_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  my_mod_gen_v1 #(.DAC_BIT(14)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_freq_cnt   (i_freq_cnt),
    .i_amp_h      (i_amp_h),
    .i_amp_l      (i_amp_l),
    .i_mod_offset (i_mod_offset),
    .o_status     (o_status),
    .o_trig       (o_trig),
    .o_mod_dac    (o_mod_dac),
    .o_period_cnt (o_period_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0]        freq;
    logic signed [31:0] ah;
    logic signed [31:0] al;
    logic signed [31:0] of;
    int                 len;
    int                 dh;
    int                 dl;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c,
                     input logic st, input logic tr,
                     input int d);
    logic signed [13:0] e;
    e = d[13:0];
    n_cmp++;
    if (o_status !== st || o_trig !== tr || o_mod_dac !== e) begin
      n_bad++;
      $display("FAIL %s c=%0d got st=%b tr=%b dac=%0d exp st=%b tr=%b dac=%0d",
               nm, c, o_status, o_trig, o_mod_dac, st, tr, e);
    end
  endtask

  task automatic chk_pc(input string nm, input int exp);
    n_cmp++;
    if (o_period_cnt !== exp[31:0]) begin
      n_bad++;
      $display("FAIL %s period_cnt got %0d exp %0d",
               nm, o_period_cnt, exp);
    end
  endtask

  task automatic do_reset();
    i_en = 1'b0;
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input logic [31:0] f, input int ah,
                     input int al, input int of);
    i_freq_cnt   = f;
    i_amp_h      = ah;
    i_amp_l      = al;
    i_mod_offset = of;
  endtask

  task automatic step_to(inout int c, input int t);
    while (c < t) begin
      tick();
      c++;
    end
  endtask

  initial begin
    int c;
    tbl[0] = '{32'd10, 32'sd1000, -32'sd1000, 32'sd50, 10, 1050, -950};
    tbl[1] = '{32'd1, 32'sd100, -32'sd100, 32'sd0, 2, 100, -100};
    tbl[2] = '{32'd0, 32'sd5, -32'sd7, 32'sd3, 2, 8, -4};
    tbl[3] = '{32'd3, 32'sd10000, -32'sd10000, 32'sd0, 3, 8191, -8192};
    tbl[4] = '{32'd4, 32'sh7FFFFFFF, 32'sh80000000, 32'sh7FFFFFFF,
               4, 8191, -1};
    tbl[5] = '{32'd5, 32'sd8000, -32'sd8000, 32'sd191, 5, 8191, -7809};

    // Reset held with enable high: nothing may move.
    cfg(32'd10, 1000, -1000, 50);
    i_en = 1'b1;
    i_rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_hold", k, 1'b0, 1'b0, 0);
      chk_pc("reset_hold", 0);
    end

    // Table-driven waveform checks: two full periods, then stop.
    for (int i = 0; i < 6; i++) begin
      int n;
      do_reset();
      cfg(tbl[i].freq, tbl[i].ah, tbl[i].al, tbl[i].of);
      n = tbl[i].len;
      i_en = 1'b1;
      for (int k = 0; k < 4 * n; k++) begin
        logic hi;
        tick();
        hi = ((k / n) % 2) == 0;
        chk($sformatf("vec%0d", i), k, hi, (k % n) == 0,
            hi ? tbl[i].dh : tbl[i].dl);
        if (k == 2 * n) chk_pc($sformatf("vec%0d_p1", i), 1);
      end
      i_en = 1'b0;
      tick();
      chk($sformatf("vec%0d_idle", i), 4 * n, 1'b0, 1'b0, 0);
      chk_pc($sformatf("vec%0d_p2", i), 2);
      tick();
      chk($sformatf("vec%0d_idle2", i), 4 * n + 1, 1'b0, 1'b0, 0);
    end

    // Period count after 100 cycles at N=10.
    do_reset();
    cfg(32'd10, 1000, -1000, 50);
    i_en = 1'b1;
    c = -1;
    step_to(c, 100);
    chk_pc("count100", 5);
    chk("count100", c, 1'b1, 1'b1, 1050);

    // Shadowing: amp_h and N change mid-HIGH take effect next period.
    do_reset();
    cfg(32'd10, 1000, -1000, 0);
    i_en = 1'b1;
    c = -1;
    step_to(c, 2);
    i_amp_h = 2000;
    i_freq_cnt = 32'd3;
    step_to(c, 9);
    chk("shadow_hi_end", c, 1'b1, 1'b0, 1000);
    step_to(c, 10);
    chk("shadow_lo", c, 1'b0, 1'b1, -1000);
    step_to(c, 19);
    chk("shadow_lo_end", c, 1'b0, 1'b0, -1000);
    step_to(c, 20);
    chk("shadow_new_hi", c, 1'b1, 1'b1, 2000);
    step_to(c, 22);
    chk("shadow_new_hi_end", c, 1'b1, 1'b0, 2000);
    step_to(c, 23);
    chk("shadow_new_lo", c, 1'b0, 1'b1, -1000);

    // Enable dropped on cycle 2 of HIGH: period completes, then IDLE.
    do_reset();
    cfg(32'd10, 1000, -1000, 50);
    i_en = 1'b1;
    c = -1;
    step_to(c, 1);
    i_en = 1'b0;
    step_to(c, 9);
    chk("stop_hi_end", c, 1'b1, 1'b0, 1050);
    step_to(c, 10);
    chk("stop_lo", c, 1'b0, 1'b1, -950);
    step_to(c, 19);
    chk("stop_lo_end", c, 1'b0, 1'b0, -950);
    chk_pc("stop_lo_end", 0);
    step_to(c, 20);
    chk("stop_idle", c, 1'b0, 1'b0, 0);
    chk_pc("stop_idle", 1);
    step_to(c, 25);
    chk("stop_idle_late", c, 1'b0, 1'b0, 0);
    chk_pc("stop_idle_late", 1);

    // Reset pulsed mid-LOW: outputs clear before any clock edge.
    do_reset();
    cfg(32'd10, 1000, -1000, 50);
    i_en = 1'b1;
    c = -1;
    step_to(c, 13);
    chk("pre_rst_lo", c, 1'b0, 1'b0, -950);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst", c, 1'b0, 1'b0, 0);
    chk_pc("async_rst", 0);
    tick();
    tick();
    chk("rst_held", c, 1'b0, 1'b0, 0);
    i_rst_n = 1'b1;
    tick();
    chk("restart", 0, 1'b1, 1'b1, 1050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_mod_gen_v1.md
# my_mod_gen_v1

Square-wave bias-modulation generator for the IRIS loop: drives the modulation DAC word and emits the phase flag (`o_status`) and the one-cycle phase-change strobe (`o_trig`) consumed by the error-signal generator's `i_status`/`i_trig` inputs. Half-period length, high/low amplitudes and DC offset are register-programmable. They are shadowed at each period start, so the error-signal generator always sees a whole, self-consistent period.

## Interface
- `DAC_BIT`, 14, width of the modulation DAC word (signed).
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_en`  in  1  run enable.
- `i_freq_cnt`  in  32  half-period length N in clocks; values 0 and 1 are treated as 2.
- `i_amp_h`  in  32 signed  DAC level during the high half.
- `i_amp_l`  in  32 signed  DAC level during the low half.
- `i_mod_offset`  in  32 signed  added to both levels.
- `o_status`  out  1  1 = high half, 0 = low half or idle.
- `o_trig`  out  1  one-cycle pulse on the first cycle of every half.
- `o_mod_dac`  out  DAC_BIT signed  saturated DAC word.
- `o_period_cnt`  out  32  completed full periods; wraps.
- `o_cstate`  out  2  FSM state (present only with `MOD_GEN_DBG_EN`).
- `o_half_cnt`  out  32  half-period counter (present only with `MOD_GEN_DBG_EN`).

## Operation
- FSM states: IDLE=0, HIGH=1, LOW=2. Reset state is IDLE.
- Shadow registers: `N`, `amp_h`, `amp_l` and `offset` are captured on every entry to HIGH. Input changes at any other time are ignored until the next HIGH entry.
- IDLE → HIGH: on a clock edge with `i_en`=1.
- HIGH → LOW: at the edge where `half_cnt`==N-1.
- LOW → HIGH or IDLE: at the edge where `half_cnt`==N-1.
  - Goes to HIGH if `i_en`=1, otherwise to IDLE.
  - `o_period_cnt` increments on either path; 0xFFFFFFFF wraps to 0.
- `i_en` deasserted mid-period: the current period always completes (HIGH and LOW, N cycles each). There is no truncated half.
- `half_cnt` resets to 0 on every state change and increments by 1 otherwise within HIGH and LOW. It is held at 0 in IDLE.
- DAC arithmetic:
  - level = `amp` + `offset`, computed in 33-bit signed.
  - Result is clamped to [-2^(DAC_BIT-1), 2^(DAC_BIT-1)-1].
  - The word uses `amp_h` in HIGH, `amp_l` in LOW, and is 0 in IDLE.
- Outputs in IDLE: `o_status`=0, `o_trig`=0, `o_mod_dac`=0. `o_period_cnt` is retained.

## Timing
- All outputs are registered.
- Reset values: `o_status`=0, `o_trig`=0, `o_mod_dac`=0, `o_period_cnt`=0, `o_cstate`=0, `o_half_cnt`=0.
- Start-up: `i_en` sampled 1 in IDLE at edge k gives, from edge k onward:
  - `o_status`=1, `o_trig`=1 for exactly one cycle, `o_mod_dac`=sat(`amp_h`+`offset`).
- Steady state:
  - `o_status` is high for N cycles, then low for N cycles.
  - `o_trig` pulses every N cycles, coincident with each `o_status` edge.
  - `o_mod_dac` changes on the same edge as `o_status`.
- Return to IDLE: `o_status` and `o_mod_dac` drop to 0 on the edge ending the last LOW half. No trig is issued on that edge.
- Reset asserted mid-operation: all outputs and the FSM go to their reset values immediately (asynchronous). Operation restarts only from IDLE after reset release.

## Configuration
- `MOD_GEN_DBG_EN` defined:
  - Ports `o_cstate` and `o_half_cnt` exist and mirror the FSM state and `half_cnt` registers.
- `MOD_GEN_DBG_EN` undefined:
  - Those ports are absent.
  - All other behaviour is identical, cycle for cycle.

## Test plan
- Reset check: hold `i_rst_n`=0 with `i_en`=1. All outputs must stay at 0.
- Basic run: N=10, `amp_h`=1000, `amp_l`=-1000, offset=50.
  - `o_status` is 10 cycles high then 10 cycles low.
  - `o_trig` is one cycle wide, every 10 cycles.
  - `o_mod_dac` alternates 1050 / -950.
  - `o_period_cnt` reaches 5 after 100 cycles.
- Minimum N: `i_freq_cnt`=1, then 0. Each half must last exactly 2 cycles, and `o_trig` must pulse every 2 cycles.
- Saturation (DAC_BIT=14): `amp_h`=10000, `amp_l`=-10000, offset=0. `o_mod_dac` must be 8191 / -8192.
- Shadowing: with N=10, change `amp_h` 1000→2000 on cycle 3 of a HIGH half.
  - The current HIGH half keeps 1000.
  - The next HIGH half shows 2000.
- Stop and reset:
  - Drop `i_en` on cycle 2 of HIGH. The period must complete (HIGH 10 cycles, LOW 10 cycles), then go to IDLE with `o_mod_dac`=0 and `o_period_cnt` incremented by 1.
  - Separately, pulse `i_rst_n` low mid-LOW. All outputs must go to 0 at once.
